// File: rtl/subcore_dispatcher.sv
// subcore_dispatcher
//
// Launch scheduler between the main core and a bank of SUBCORE_NUM subcores.
// Single launches go to the first idle subcore at or after a round-robin
// pointer; broadcast launches start every subcore with the same PC. A join
// barrier reports when every subcore has gone idle again.
//
// Ports
//   clk, rstn          : clock, synchronous active-low reset
//   launch_valid/ready : launch handshake from the main core
//   launch_bcast       : launch on all subcores at once
//   launch_pc          : start PC of the launch
//   launch_id          : subcore chosen by the last single launch
//   exec_requested     : one-cycle start pulse per subcore
//   requested_pc       : PC accompanying exec_requested (held otherwise)
//   subcore_ended      : one-cycle completion pulse per subcore
//   join_req/join_done : barrier request pulse / barrier satisfied pulse
//   busy_mask          : registered per-subcore busy bits
//   active_count       : population count of busy_mask
//   protocol_err       : sticky flag, ended pulse from an idle subcore
module subcore_dispatcher #(
  parameter int SUBCORE_NUM = 8,
  parameter int PC_W        = 32,
  parameter int ID_W        = $clog2(SUBCORE_NUM)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   launch_valid,
  input  logic                   launch_bcast,
  input  logic [PC_W-1:0]        launch_pc,
  output logic                   launch_ready,
  output logic [ID_W-1:0]        launch_id,
  output logic [SUBCORE_NUM-1:0] exec_requested,
  output logic [PC_W-1:0]        requested_pc,
  input  logic [SUBCORE_NUM-1:0] subcore_ended,
  input  logic                   join_req,
  output logic                   join_done,
  output logic [SUBCORE_NUM-1:0] busy_mask,
  output logic [ID_W:0]          active_count,
  output logic                   protocol_err
);

  typedef enum logic {ST_RUN, ST_JOIN} state_t;

  state_t                 state_q, state_d;
  logic [SUBCORE_NUM-1:0] busy_q, busy_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SUBCORE_NUM-1:0] exec_q, exec_d;
  logic [PC_W-1:0]        req_pc_q, req_pc_d;
  logic [ID_W-1:0]        launch_id_q, launch_id_d;
  logic                   join_done_q, join_done_d;
  logic                   err_q, err_d;
  logic [ID_W:0]          active_count_q, active_count_d;

  logic                   fire;
  logic [ID_W-1:0]        sel;
  logic                   sel_found;
  logic [ID_W:0]          cand;

  // Ready depends only on registered state plus the broadcast qualifier,
  // so a subcore freed this cycle is not visible until the next one.
  always_comb begin
    launch_ready = 1'b0;
    if (state_q == ST_RUN) begin
      if (launch_bcast) launch_ready = (busy_q == '0);
      else              launch_ready = (busy_q != '1);
    end
  end

  assign fire = launch_valid && launch_ready;

  // Round-robin search: first idle index at or after rr_ptr, wrapping at
  // SUBCORE_NUM (which need not be a power of two, hence the explicit wrap).
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < SUBCORE_NUM; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(SUBCORE_NUM)) cand = cand - (ID_W+1)'(SUBCORE_NUM);
      if (!sel_found && !busy_q[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel       = cand[ID_W-1:0];
      end
    end
  end

  // Completions clear busy bits first, then a dispatch sets its bit, so a
  // dispatch colliding with a stray ended pulse on the same subcore wins.
  always_comb begin
    busy_d      = busy_q & ~subcore_ended;
    err_d       = err_q | (|(subcore_ended & ~busy_q));
    exec_d      = '0;
    req_pc_d    = req_pc_q;
    launch_id_d = launch_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (fire) begin
      req_pc_d = launch_pc;
      if (launch_bcast) begin
        busy_d = '1;
        exec_d = '1;
      end else begin
        busy_d[sel] = 1'b1;
        exec_d[sel] = 1'b1;
        launch_id_d = sel;
        rr_ptr_d    = (sel == ID_W'(SUBCORE_NUM-1)) ? '0 : sel + ID_W'(1);
      end
    end
  end

  always_comb begin
    active_count_d = '0;
    for (int i = 0; i < SUBCORE_NUM; i++) begin
      active_count_d = active_count_d + (ID_W+1)'(busy_d[i]);
    end
  end

  // A join request that finds everything already idle (after this edge)
  // completes immediately and never leaves RUN.
  always_comb begin
    state_d     = state_q;
    join_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (join_req) begin
          if (busy_d == '0) join_done_d = 1'b1;
          else              state_d     = ST_JOIN;
        end
      end
      ST_JOIN: begin
        if (busy_d == '0) begin
          state_d     = ST_RUN;
          join_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= ST_RUN;
      busy_q         <= '0;
      rr_ptr_q       <= '0;
      exec_q         <= '0;
      req_pc_q       <= '0;
      launch_id_q    <= '0;
      join_done_q    <= 1'b0;
      err_q          <= 1'b0;
      active_count_q <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      rr_ptr_q       <= rr_ptr_d;
      exec_q         <= exec_d;
      req_pc_q       <= req_pc_d;
      launch_id_q    <= launch_id_d;
      join_done_q    <= join_done_d;
      err_q          <= err_d;
      active_count_q <= active_count_d;
    end
  end

  assign exec_requested = exec_q;
  assign requested_pc   = req_pc_q;
  assign launch_id      = launch_id_q;
  assign join_done      = join_done_q;
  assign busy_mask      = busy_q;
  assign active_count   = active_count_q;
  assign protocol_err   = err_q;

endmodule

// File: tb/tb_subcore_dispatcher.sv
// Bench for subcore_dispatcher: three instances (8, 5 and 2 subcores) share
// the same stimulus. A table of hand-derived vectors exercises the 8-subcore
// instance, and every instance is also compared each cycle against an
// abstract model of the dispatch rules.
module tb_subcore_dispatcher;

  logic        clk = 1'b0;
  logic        rstn;
  logic        launch_valid;
  logic        launch_bcast;
  logic [31:0] launch_pc;
  logic        join_req;
  logic [63:0] ended_all;

  logic        rdy8, jd8, err8;
  logic [2:0]  id8;
  logic [7:0]  exec8, busy8;
  logic [31:0] rpc8;
  logic [3:0]  cnt8;

  logic        rdy5, jd5, err5;
  logic [2:0]  id5;
  logic [4:0]  exec5, busy5;
  logic [31:0] rpc5;
  logic [3:0]  cnt5;

  logic        rdy2, jd2, err2;
  logic [0:0]  id2;
  logic [1:0]  exec2, busy2;
  logic [31:0] rpc2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  subcore_dispatcher #(.SUBCORE_NUM(8)) dut8 (
    .clk(clk), .rstn(rstn), .launch_valid(launch_valid), .launch_bcast(launch_bcast),
    .launch_pc(launch_pc), .launch_ready(rdy8), .launch_id(id8), .exec_requested(exec8),
    .requested_pc(rpc8), .subcore_ended(ended_all[7:0]), .join_req(join_req),
    .join_done(jd8), .busy_mask(busy8), .active_count(cnt8), .protocol_err(err8));

  subcore_dispatcher #(.SUBCORE_NUM(5)) dut5 (
    .clk(clk), .rstn(rstn), .launch_valid(launch_valid), .launch_bcast(launch_bcast),
    .launch_pc(launch_pc), .launch_ready(rdy5), .launch_id(id5), .exec_requested(exec5),
    .requested_pc(rpc5), .subcore_ended(ended_all[4:0]), .join_req(join_req),
    .join_done(jd5), .busy_mask(busy5), .active_count(cnt5), .protocol_err(err5));

  subcore_dispatcher #(.SUBCORE_NUM(2)) dut2 (
    .clk(clk), .rstn(rstn), .launch_valid(launch_valid), .launch_bcast(launch_bcast),
    .launch_pc(launch_pc), .launch_ready(rdy2), .launch_id(id2), .exec_requested(exec2),
    .requested_pc(rpc2), .subcore_ended(ended_all[1:0]), .join_req(join_req),
    .join_done(jd2), .busy_mask(busy2), .active_count(cnt2), .protocol_err(err2));

  int errors = 0;
  int checks = 0;

  // Abstract view of one dispatcher: who is busy, where the next search
  // starts, whether a barrier is pending, and the last outputs produced.
  typedef struct {
    logic [63:0] busy;
    int          rr;
    bit          joining;
    bit          err;
    logic [63:0] exec;
    logic [31:0] rpc;
    int          id;
    bit          jd;
  } mstate_t;

  mstate_t m [3];
  int      nsz [3] = '{8, 5, 2};
  bit      model_valid = 1'b0;
  logic    rdy8_pre;

  typedef struct {
    bit          r, lv, bc;
    logic [31:0] pc;
    logic [7:0]  en;
    bit          jr;
    bit          rdy;
    logic [7:0]  ex;
    logic [31:0] rp;
    logic [2:0]  id;
    logic [7:0]  b;
    logic [3:0]  c;
    bit          jd, er;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mkVec(bit r, bit lv, bit bc, logic [31:0] pc, logic [7:0] en, bit jr,
                                 bit rdy, logic [7:0] ex, logic [31:0] rp, logic [2:0] id,
                                 logic [7:0] b, logic [3:0] c, bit jd, bit er);
    vec_t v;
    v.r = r; v.lv = lv; v.bc = bc; v.pc = pc; v.en = en; v.jr = jr;
    v.rdy = rdy; v.ex = ex; v.rp = rp; v.id = id; v.b = b; v.c = c; v.jd = jd; v.er = er;
    return v;
  endfunction

  function automatic logic [63:0] maskOf(int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic bit modelReady(mstate_t s, int n, bit bc);
    if (s.joining) return 1'b0;
    if (bc)        return s.busy == 64'd0;
    return s.busy != maskOf(n);
  endfunction

  function automatic mstate_t modelStep(mstate_t s, int n, bit r, bit lv, bit bc,
                                        logic [31:0] pc, logic [63:0] en, bit jr);
    mstate_t t;
    bit      fire;
    int      pick;
    if (!r) begin
      t.busy = '0; t.rr = 0; t.joining = 1'b0; t.err = 1'b0;
      t.exec = '0; t.rpc = '0; t.id = 0; t.jd = 1'b0;
      return t;
    end
    t = s;
    t.exec = '0;
    t.jd   = 1'b0;
    fire = lv && modelReady(s, n, bc);
    for (int i = 0; i < n; i++) begin
      if (en[i]) begin
        if (s.busy[i]) t.busy[i] = 1'b0;
        else           t.err     = 1'b1;
      end
    end
    if (fire && bc) begin
      t.busy = maskOf(n);
      t.exec = maskOf(n);
      t.rpc  = pc;
    end else if (fire) begin
      pick = -1;
      for (int k = 0; k < n; k++) begin
        if (pick < 0 && !s.busy[(s.rr + k) % n]) pick = (s.rr + k) % n;
      end
      t.busy[pick] = 1'b1;
      t.exec       = 64'd1 << pick;
      t.rpc        = pc;
      t.id         = pick;
      t.rr         = (pick + 1) % n;
    end
    if (!s.joining) begin
      if (jr) begin
        if (t.busy == 64'd0) t.jd = 1'b1;
        else                 t.joining = 1'b1;
      end
    end else if (t.busy == 64'd0) begin
      t.joining = 1'b0;
      t.jd      = 1'b1;
    end
    return t;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVsModel(string tag, int k, logic [63:0] ex, logic [63:0] rp,
                              logic [63:0] id, logic [63:0] b, logic [63:0] c,
                              logic jd, logic er);
    checkOutput({tag, "_exec"}, ex, m[k].exec);
    checkOutput({tag, "_rpc"},  rp, 64'(m[k].rpc));
    checkOutput({tag, "_id"},   id, 64'(m[k].id));
    checkOutput({tag, "_busy"}, b,  m[k].busy);
    checkOutput({tag, "_cnt"},  c,  64'($countones(m[k].busy)));
    checkOutput({tag, "_jd"},   64'(jd), 64'(m[k].jd));
    checkOutput({tag, "_err"},  64'(er), 64'(m[k].err));
  endtask

  // One clock cycle: drive at the falling edge, check ready before the
  // rising edge, advance the model, then check registered outputs after it.
  task automatic applyStimulus(bit r, bit lv, bit bc, logic [31:0] pc, logic [63:0] en, bit jr);
    @(negedge clk);
    rstn = r; launch_valid = lv; launch_bcast = bc; launch_pc = pc;
    ended_all = en; join_req = jr;
    #1;
    rdy8_pre = rdy8;
    if (model_valid) begin
      checkOutput("n8_ready", 64'(rdy8), 64'(modelReady(m[0], nsz[0], bc)));
      checkOutput("n5_ready", 64'(rdy5), 64'(modelReady(m[1], nsz[1], bc)));
      checkOutput("n2_ready", 64'(rdy2), 64'(modelReady(m[2], nsz[2], bc)));
    end
    for (int k = 0; k < 3; k++) m[k] = modelStep(m[k], nsz[k], r, lv, bc, pc, en, jr);
    if (!r) model_valid = 1'b1;
    @(posedge clk);
    #1;
    if (model_valid) begin
      checkVsModel("n8", 0, 64'(exec8), 64'(rpc8), 64'(id8), 64'(busy8), 64'(cnt8), jd8, err8);
      checkVsModel("n5", 1, 64'(exec5), 64'(rpc5), 64'(id5), 64'(busy5), 64'(cnt5), jd5, err5);
      checkVsModel("n2", 2, 64'(exec2), 64'(rpc2), 64'(id2), 64'(busy2), 64'(cnt2), jd2, err2);
    end
  endtask

  initial begin
    rstn = 1'b0; launch_valid = 1'b0; launch_bcast = 1'b0;
    launch_pc = '0; join_req = 1'b0; ended_all = '0;

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);

    // Reset state of the 8-subcore instance.
    checkOutput("rst_exec", 64'(exec8), 64'h0);
    checkOutput("rst_rpc",  64'(rpc8),  64'h0);
    checkOutput("rst_id",   64'(id8),   64'h0);
    checkOutput("rst_busy", 64'(busy8), 64'h0);
    checkOutput("rst_cnt",  64'(cnt8),  64'h0);
    checkOutput("rst_jd",   64'(jd8),   64'h0);
    checkOutput("rst_err",  64'(err8),  64'h0);
    checkOutput("rst_rdy",  64'(rdy8),  64'h1);

    // Eight back-to-back single launches.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mkVec(1, 1, 0, 32'(32'h100 + i), 8'h00, 0, 1, 8'(1 << i), 32'(32'h100 + i),
                          3'(i), 8'((2 << i) - 1), 4'(i + 1), 0, 0));
    // Full, then wrap-around reselection of freed subcores 3 and 1.
    tbl.push_back(mkVec(1, 1, 0, 32'h999,  8'h00, 0, 0, 8'h00, 32'h107,  3'd7, 8'hFF, 4'd8, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h08, 0, 0, 8'h00, 32'h107,  3'd7, 8'hF7, 4'd7, 0, 0));
    tbl.push_back(mkVec(1, 1, 0, 32'h300,  8'h00, 0, 1, 8'h08, 32'h300,  3'd3, 8'hFF, 4'd8, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h02, 0, 0, 8'h00, 32'h300,  3'd3, 8'hFD, 4'd7, 0, 0));
    tbl.push_back(mkVec(1, 1, 0, 32'h301,  8'h00, 0, 1, 8'h02, 32'h301,  3'd1, 8'hFF, 4'd8, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'hFF, 0, 0, 8'h00, 32'h301,  3'd1, 8'h00, 4'd0, 0, 0));
    // Broadcast, then a refused broadcast with one subcore still busy.
    tbl.push_back(mkVec(1, 1, 1, 32'h2000, 8'h00, 0, 1, 8'hFF, 32'h2000, 3'd1, 8'hFF, 4'd8, 0, 0));
    tbl.push_back(mkVec(1, 0, 1, 32'h0,    8'h01, 0, 0, 8'h00, 32'h2000, 3'd1, 8'hFE, 4'd7, 0, 0));
    tbl.push_back(mkVec(1, 1, 1, 32'h3000, 8'h00, 0, 0, 8'h00, 32'h2000, 3'd1, 8'hFE, 4'd7, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'hF8, 0, 1, 8'h00, 32'h2000, 3'd1, 8'h06, 4'd2, 0, 0));
    tbl.push_back(mkVec(1, 1, 0, 32'h400,  8'h00, 0, 1, 8'h08, 32'h400,  3'd3, 8'h0E, 4'd3, 0, 0));
    // Join with three busy, ended on three separate cycles.
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h00, 1, 1, 8'h00, 32'h400,  3'd3, 8'h0E, 4'd3, 0, 0));
    tbl.push_back(mkVec(1, 1, 0, 32'h500,  8'h00, 0, 0, 8'h00, 32'h400,  3'd3, 8'h0E, 4'd3, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h02, 0, 0, 8'h00, 32'h400,  3'd3, 8'h0C, 4'd2, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h04, 0, 0, 8'h00, 32'h400,  3'd3, 8'h08, 4'd1, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h08, 0, 0, 8'h00, 32'h400,  3'd3, 8'h00, 4'd0, 1, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h00, 0, 1, 8'h00, 32'h400,  3'd3, 8'h00, 4'd0, 0, 0));
    // Join while idle completes on the next cycle.
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h00, 1, 1, 8'h00, 32'h400,  3'd3, 8'h00, 4'd0, 1, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h00, 0, 1, 8'h00, 32'h400,  3'd3, 8'h00, 4'd0, 0, 0));
    // Stray ended from idle subcore 5, sticky error, reset clears it.
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h20, 0, 1, 8'h00, 32'h400,  3'd3, 8'h00, 4'd0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h00, 0, 1, 8'h00, 32'h400,  3'd3, 8'h00, 4'd0, 0, 1));
    tbl.push_back(mkVec(0, 1, 0, 32'h777,  8'h00, 0, 1, 8'h00, 32'h0,    3'd0, 8'h00, 4'd0, 0, 0));
    // Ended colliding with a dispatch to the same subcore: dispatch wins.
    tbl.push_back(mkVec(1, 1, 0, 32'h600,  8'h01, 0, 1, 8'h01, 32'h600,  3'd0, 8'h01, 4'd1, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h00, 0, 1, 8'h00, 32'h600,  3'd0, 8'h01, 4'd1, 0, 1));
    // Reset with a subcore in flight; its later ended pulse is an error.
    tbl.push_back(mkVec(0, 0, 0, 32'h0,    8'h00, 0, 1, 8'h00, 32'h0,    3'd0, 8'h00, 4'd0, 0, 0));
    tbl.push_back(mkVec(1, 0, 0, 32'h0,    8'h01, 0, 1, 8'h00, 32'h0,    3'd0, 8'h00, 4'd0, 0, 1));

    foreach (tbl[v]) begin
      applyStimulus(tbl[v].r, tbl[v].lv, tbl[v].bc, tbl[v].pc, 64'(tbl[v].en), tbl[v].jr);
      checkOutput($sformatf("vec%0d_ready", v), 64'(rdy8_pre), 64'(tbl[v].rdy));
      checkOutput($sformatf("vec%0d_exec", v),  64'(exec8), 64'(tbl[v].ex));
      checkOutput($sformatf("vec%0d_rpc", v),   64'(rpc8),  64'(tbl[v].rp));
      checkOutput($sformatf("vec%0d_id", v),    64'(id8),   64'(tbl[v].id));
      checkOutput($sformatf("vec%0d_busy", v),  64'(busy8), 64'(tbl[v].b));
      checkOutput($sformatf("vec%0d_cnt", v),   64'(cnt8),  64'(tbl[v].c));
      checkOutput($sformatf("vec%0d_jd", v),    64'(jd8),   64'(tbl[v].jd));
      checkOutput($sformatf("vec%0d_err", v),   64'(err8),  64'(tbl[v].er));
    end

    // Randomized traffic on all three sizes against the model.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 99) >= 2,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0,
                    32'($urandom),
                    {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)} &
                    {32'($urandom), 32'($urandom)},
                    $urandom_range(0, 19) == 0);
      checkOutput("n5_id_range", 64'(id5 < 3'd5), 64'h1);
      checkOutput("n2_id_range", 64'(id2 < 1'b1 || id2 == 1'b1), 64'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subcore_dispatcher.md
# subcore_dispatcher

Parametrised launch scheduler between the main core and a bank of `SUBCORE_NUM` subcores, the successor to the fixed 8-subcore point-to-point wiring. It accepts launch requests (a start PC) from the main core over a valid/ready handshake and picks an idle subcore round-robin. It issues the per-subcore `exec_requested` pulse with the PC and tracks busy state from `subcore_ended` pulses. It also provides a broadcast-launch mode (all subcores, same PC) and a join/barrier that reports when every subcore has finished.

## Interface
- `SUBCORE_NUM`, 8: number of subcores; legal range 2..64.
- `PC_W`, 32: width of the program counter.
- `ID_W`, `$clog2(SUBCORE_NUM)`: subcore index width (derived; do not override).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `launch_valid`  in  1  main core requests a launch.
- `launch_bcast`  in  1  qualifies `launch_valid`: launch on all subcores at once.
- `launch_pc`  in  PC_W  start PC for the launch.
- `launch_ready`  out  1  dispatcher accepts this cycle.
- `launch_id`  out  ID_W  index of the subcore chosen by the last single launch.
- `exec_requested`  out  SUBCORE_NUM  one-cycle start pulse per subcore.
- `requested_pc`  out  PC_W  PC that accompanies `exec_requested`; shared by all subcores.
- `subcore_ended`  in  SUBCORE_NUM  one-cycle completion pulse per subcore.
- `join_req`  in  1  one-cycle pulse: wait until all subcores are idle.
- `join_done`  out  1  one-cycle pulse: barrier satisfied.
- `busy_mask`  out  SUBCORE_NUM  registered per-subcore busy bits.
- `active_count`  out  ID_W+1  population count of `busy_mask`.
- `protocol_err`  out  1  sticky error flag.

## Operation
- State: `busy[SUBCORE_NUM]`, `rr_ptr[ID_W]`, FSM {RUN, JOIN}, `protocol_err`.
- Reset values (`rstn`=0 at an edge): `busy`=0, `rr_ptr`=0, FSM=RUN, `exec_requested`=0, `requested_pc`=0, `launch_id`=0, `join_done`=0, `protocol_err`=0, `active_count`=0.
- `launch_ready` is combinational from registered state only:
  - RUN and `launch_bcast`=0: ready while at least one `busy` bit is 0.
  - RUN and `launch_bcast`=1: ready only when `busy`==0.
  - JOIN: ready is 0.
- A launch fires when `launch_valid` && `launch_ready`.
- Single-launch selection: the first idle index at or after `rr_ptr`, searching upward and wrapping modulo `SUBCORE_NUM`. On fire:
  - `busy[sel]` is set.
  - `exec_requested` = one-hot(sel) for exactly one cycle.
  - `requested_pc` and `launch_pc` are registered.
  - `launch_id` = sel.
  - `rr_ptr` = (sel+1) mod `SUBCORE_NUM`.
- Broadcast fire:
  - `busy` = all ones.
  - `exec_requested` = all ones for one cycle; `requested_pc` = `launch_pc`.
  - `rr_ptr` and `launch_id` are unchanged.
- `subcore_ended[i]` with `busy[i]`=1 clears `busy[i]` at that edge. Several ended bits in one cycle are all honoured.
- `subcore_ended[i]` with `busy[i]`=0 is ignored for busy tracking and sets `protocol_err`. This also covers ended in the same cycle as dispatch to i: the dispatch wins, `busy[i]`=1, and the error is flagged.
- A subcore freed by `subcore_ended` is not selectable until the following cycle, because selection uses registered `busy`.
- `requested_pc` holds its last value when `exec_requested`=0.
- FSM transitions:
  - RUN to JOIN when `join_req`=1. A launch firing in that same cycle is still accepted and counts toward the barrier.
  - JOIN to RUN when the next-state `busy` is 0; `join_done` pulses in the cycle after that edge.
  - `join_req` while in JOIN is ignored.
- `protocol_err` clears only on reset.

## Timing
- Launch latency: fire sampled at edge k gives `exec_requested`/`requested_pc`/`launch_id`/`busy_mask` valid in the cycle after edge k.
- Throughput: one single launch per cycle while idle subcores remain.
- Completion: `subcore_ended` sampled at edge k gives the `busy_mask` bit low after edge k and `launch_ready` reflecting it in the same cycle.
- Join latency:
  - `join_req` with `busy`==0 at edge k: `join_done` high in the cycle after edge k.
  - Otherwise `join_done` is high in the cycle after the edge that clears the last busy bit.
- `active_count` is registered alongside `busy_mask`; no extra latency.
- Reset mid-operation: all state returns to reset values at the reset edge. In-flight subcores are forgotten, and their later `subcore_ended` pulses raise `protocol_err`.

## Test plan
- Reset, `SUBCORE_NUM`=8: 8 back-to-back single launches with PCs 0x100..0x107 -> `exec_requested` pulses 0x01,0x02,..,0x80 on consecutive cycles with matching `requested_pc`, `launch_id` 0..7; `launch_ready`=0 after the 8th; `active_count`=8.
- Wrap-around: all busy, `rr_ptr`=0; end subcore 3 then launch -> selects 3, `rr_ptr`=4. Then end 1 and launch -> selects 1 (wrapped search), `rr_ptr`=2.
- Broadcast: idle, `launch_bcast`=1, PC 0x2000 -> `exec_requested`=0xFF for one cycle, `busy_mask`=0xFF. A broadcast with one busy subcore -> `launch_ready`=0 and no pulse.
- Join: 3 subcores busy, `join_req` -> `launch_ready`=0. End pulses on 3 separate cycles -> `join_done` exactly one cycle after the last edge, then FSM back in RUN. `join_req` while idle -> `join_done` next cycle.
- Errors/simultaneity: `subcore_ended[5]` while idle -> `protocol_err`=1 and sticky. Ended[2] in the same cycle as dispatch to 2 -> `busy[2]`=1, error set. Reset asserted mid-run -> all outputs at reset values the next cycle.
- Parameter sweep: `SUBCORE_NUM`=2 and 5 (non-power-of-two) -> round-robin wraps at N-1 and `launch_id` never ≥ N.
